// File: rtl/pic_inta_sequencer_pkg.sv
// Shared types and constants for the 8259A interrupt-acknowledge sequencer.
package pic_inta_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    GAP  = 2'd2,
    HOLD = 2'd3
  } inta_state_t;

  // First byte returned by the PIC in MCS-80 mode must be a CALL opcode.
  localparam logic [7:0] CALL_OPCODE  = 8'hCD;
  localparam int         PULSES_8086  = 2;
  localparam int         PULSES_MCS80 = 3;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pic_inta_sequencer_if.sv
// PIC-side pins and CPU-side vector handshake of the INTA sequencer.
// PIC_INTA_STATS_EN adds the sequence/error counter outputs.
interface pic_inta_if;
  logic        enable;
  logic        interrupt_to_cpu;
  logic        u8086_or_mcs80_mode;
  logic [7:0]  data_bus;
  logic        interrupt_acknowledge_n;
  logic        busy;
  logic        vector_valid;
  logic        vector_ready;
  logic [15:0] vector_data;
  logic        opcode_error;
`ifdef PIC_INTA_STATS_EN
  logic [15:0] sequence_count;
  logic [7:0]  error_count;
`endif

  // master: the sequencer; slave: PIC/CPU side (or a bench standing in for them)
  modport master (
    input  enable, interrupt_to_cpu, u8086_or_mcs80_mode, data_bus, vector_ready,
    output interrupt_acknowledge_n, busy, vector_valid, vector_data, opcode_error
`ifdef PIC_INTA_STATS_EN
    , output sequence_count, error_count
`endif
  );

  modport slave (
    output enable, interrupt_to_cpu, u8086_or_mcs80_mode, data_bus, vector_ready,
    input  interrupt_acknowledge_n, busy, vector_valid, vector_data, opcode_error
`ifdef PIC_INTA_STATS_EN
    , input sequence_count, error_count
`endif
  );
endinterface

// File: rtl/pic_inta_sequencer_timer.sv
// Loadable down-counter timing INTA low/high widths. value counts the cycles
// remaining in the current phase including the present one, so expired marks
// the last cycle of the phase. It stops at zero and only wraps by reload.
module inta_pulse_timer #(
  parameter int W = 3
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         count_en,
  output logic [W-1:0] value,
  output logic         expired
);
  logic [W-1:0] value_q, value_d;

  // reload takes priority over counting; never decrement below zero
  always_comb begin
    value_d = value_q;
    if (load)                         value_d = load_value;
    else if (count_en && value_q != '0) value_d = value_q - 1'b1;
  end

  // counter register
  always_ff @(posedge clock) begin
    if (!reset_n) value_q <= '0;
    else          value_q <= value_d;
  end

  assign value   = value_q;
  assign expired = (value_q == W'(1));
endmodule

// File: rtl/pic_inta_sequencer.sv
// CPU-side INTA sequencer for the 8259A: drives 2 (8086) or 3 (MCS-80) INTA
// pulses, captures the PIC's bytes and offers the vector on valid/ready.
// Optional: PIC_INTA_STATS_EN adds saturating handshake/error counters.
module pic_inta_sequencer
  import pic_inta_pkg::*;
#(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2
) (
  input logic        clock,
  input logic        reset_n,
  pic_inta_if.master bus
);
  localparam int TMR_W = $clog2(imax(PULSE_CYCLES, GAP_CYCLES) + 1);

  inta_state_t       state_q, state_d;
  logic              mode_q;          // 1 = 8086, latched at start
  logic [1:0]        idx_q;           // current pulse index
  logic [2:0][7:0]   byte_q;

  logic              tmr_load, tmr_count, tmr_expired;
  logic [TMR_W-1:0]  tmr_load_val, tmr_value;
  logic              start, last_low, gap_done, last_idx, handshake;

  assign start     = (state_q == IDLE) & bus.enable & bus.interrupt_to_cpu;
  assign last_low  = (state_q == LOW) & tmr_expired;
  assign gap_done  = (state_q == GAP) & tmr_expired;
  assign last_idx  = (idx_q == (mode_q ? 2'(PULSES_8086 - 1) : 2'(PULSES_MCS80 - 1)));
  assign handshake = (state_q == HOLD) & bus.vector_ready;

  // the counter value itself is only observed through expired
  wire unused_tmr_value = ^tmr_value;

  // timer reload at each phase entry; runs only while pulsing
  always_comb begin
    tmr_load     = start | (last_low & ~last_idx) | gap_done;
    tmr_load_val = last_low ? TMR_W'(GAP_CYCLES) : TMR_W'(PULSE_CYCLES);
    tmr_count    = (state_q == LOW) | (state_q == GAP);
  end

  inta_pulse_timer #(.W(TMR_W)) u_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (tmr_load),
    .load_value (tmr_load_val),
    .count_en   (tmr_count),
    .value      (tmr_value),
    .expired    (tmr_expired)
  );

  // state register
  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // next state: once started, a sequence ignores enable/INT until HOLD
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)       state_d = LOW;
      LOW:     if (tmr_expired) state_d = last_idx ? HOLD : GAP;
      GAP:     if (tmr_expired) state_d = LOW;
      HOLD:    if (handshake)   state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // mode latch, pulse index and byte capture at the end of each low phase
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      mode_q <= 1'b0;
      idx_q  <= '0;
      byte_q <= '0;
    end else begin
      if (start) begin
        mode_q <= bus.u8086_or_mcs80_mode;
        idx_q  <= '0;
      end
      if (gap_done) idx_q <= idx_q + 2'd1;
      if (last_low) byte_q[idx_q] <= bus.data_bus;
    end
  end

  // outputs decoded from state; INTA follows state so reset lifts it at once
  always_comb begin
    bus.interrupt_acknowledge_n = (state_q != LOW);
    bus.busy                    = (state_q != IDLE);
    bus.vector_valid            = (state_q == HOLD);
    bus.vector_data             = mode_q ? {8'h00, byte_q[1]} : {byte_q[2], byte_q[1]};
    bus.opcode_error            = (state_q == HOLD) & ~mode_q & (byte_q[0] != CALL_OPCODE);
  end

`ifdef PIC_INTA_STATS_EN
  logic [15:0] seq_cnt_q;
  logic [7:0]  err_cnt_q;

  // saturating counts of accepted vectors and of bad-opcode vectors
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      seq_cnt_q <= '0;
      err_cnt_q <= '0;
    end else if (handshake) begin
      if (seq_cnt_q != '1) seq_cnt_q <= seq_cnt_q + 16'd1;
      if (bus.opcode_error && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign bus.sequence_count = seq_cnt_q;
  assign bus.error_count    = err_cnt_q;
`endif
endmodule

// File: tb/tb_pic_inta_sequencer.sv
module tb_pic_inta_sequencer;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  pic_inta_if bus();

  pic_inta_sequencer #(.PULSE_CYCLES(4), .GAP_CYCLES(2)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  // PIC model: byte index advances each time INTA returns high
  int pcnt  = 0;
  int pbase = 0;
  logic [7:0] pic_bytes [3];
  always @(posedge bus.interrupt_acknowledge_n) pcnt = pcnt + 1;
  assign bus.data_bus = (pcnt - pbase == 0) ? pic_bytes[0] :
                        (pcnt - pbase == 1) ? pic_bytes[1] :
                        (pcnt - pbase == 2) ? pic_bytes[2] : 8'h00;

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    total++; if (bus.interrupt_acknowledge_n !== 1'b1) begin bad++; $display("FAIL rst_inta: got %b want 1", bus.interrupt_acknowledge_n); end
    total++; if (bus.vector_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", bus.vector_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    total++; if (bus.opcode_error !== 1'b0) begin bad++; $display("FAIL rst_operr: got %b want 0", bus.opcode_error); end
    total++; if (bus.vector_data !== 16'h0000) begin bad++; $display("FAIL rst_data: got %h want 0000", bus.vector_data); end
`ifdef PIC_INTA_STATS_EN
    total++; if (bus.sequence_count !== 16'h0) begin bad++; $display("FAIL rst_seqcnt: got %h want 0", bus.sequence_count); end
    total++; if (bus.error_count !== 8'h0) begin bad++; $display("FAIL rst_errcnt: got %h want 0", bus.error_count); end
`endif
    reset_n = 1'b1;
    @(negedge clock);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_release_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_8086();
    logic exp;
    pbase = pcnt;
    pic_bytes[0] = 8'hFF; pic_bytes[1] = 8'h48; pic_bytes[2] = 8'h00;
    bus.u8086_or_mcs80_mode = 1'b1; bus.vector_ready = 1'b0; bus.enable = 1'b1;
    bus.interrupt_to_cpu = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      exp = ((k >= 1 && k <= 4) || (k >= 7 && k <= 10)) ? 1'b0 : 1'b1;
      total++; if (bus.interrupt_acknowledge_n !== exp) begin bad++; $display("FAIL m86_inta_k%0d: got %b want %b", k, bus.interrupt_acknowledge_n, exp); end
      total++; if (bus.vector_valid !== 1'b0) begin bad++; $display("FAIL m86_early_valid_k%0d: got %b want 0", k, bus.vector_valid); end
    end
    @(negedge clock);
    total++; if (bus.vector_valid !== 1'b1) begin bad++; $display("FAIL m86_valid: got %b want 1", bus.vector_valid); end
    total++; if (bus.interrupt_acknowledge_n !== 1'b1) begin bad++; $display("FAIL m86_inta_hold: got %b want 1", bus.interrupt_acknowledge_n); end
    total++; if (bus.vector_data !== 16'h0048) begin bad++; $display("FAIL m86_data: got %h want 0048", bus.vector_data); end
    total++; if (bus.opcode_error !== 1'b0) begin bad++; $display("FAIL m86_operr: got %b want 0", bus.opcode_error); end
    bus.vector_ready = 1'b1; bus.interrupt_to_cpu = 1'b0;
    @(negedge clock);
    total++; if (bus.busy !== 1'b0 || bus.vector_valid !== 1'b0) begin bad++; $display("FAIL m86_done: got busy=%b valid=%b want 0 0", bus.busy, bus.vector_valid); end
    bus.vector_ready = 1'b0;
  endtask

  task automatic test_mcs80();
    logic exp;
    pbase = pcnt;
    pic_bytes[0] = 8'hCD; pic_bytes[1] = 8'h20; pic_bytes[2] = 8'h13;
    bus.u8086_or_mcs80_mode = 1'b0; bus.vector_ready = 1'b0; bus.enable = 1'b1;
    bus.interrupt_to_cpu = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clock);
      if (k == 2) bus.u8086_or_mcs80_mode = 1'b1;  // must be ignored
      exp = (((k - 1) % 6) < 4) ? 1'b0 : 1'b1;
      total++; if (bus.interrupt_acknowledge_n !== exp) begin bad++; $display("FAIL m80_inta_k%0d: got %b want %b", k, bus.interrupt_acknowledge_n, exp); end
    end
    @(negedge clock);
    total++; if (bus.vector_valid !== 1'b1) begin bad++; $display("FAIL m80_valid: got %b want 1", bus.vector_valid); end
    total++; if (bus.vector_data !== 16'h1320) begin bad++; $display("FAIL m80_data: got %h want 1320", bus.vector_data); end
    total++; if (bus.opcode_error !== 1'b0) begin bad++; $display("FAIL m80_operr: got %b want 0", bus.opcode_error); end
    bus.vector_ready = 1'b1; bus.interrupt_to_cpu = 1'b0;
    @(negedge clock);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL m80_done_busy: got %b want 0", bus.busy); end
    bus.vector_ready = 1'b0;
  endtask

  task automatic test_opcode_error();
    int n = 0;
`ifdef PIC_INTA_STATS_EN
    logic [7:0]  err0;
    logic [15:0] seq0;
    err0 = bus.error_count; seq0 = bus.sequence_count;
`endif
    pbase = pcnt;
    pic_bytes[0] = 8'hC3; pic_bytes[1] = 8'h20; pic_bytes[2] = 8'h13;
    bus.u8086_or_mcs80_mode = 1'b0; bus.vector_ready = 1'b0;
    bus.interrupt_to_cpu = 1'b1;
    @(negedge clock);
    bus.interrupt_to_cpu = 1'b0;
    while (bus.vector_valid !== 1'b1 && n < 60) begin @(negedge clock); n++; end
    total++; if (bus.vector_valid !== 1'b1) begin bad++; $display("FAIL operr_timeout: got valid=%b want 1", bus.vector_valid); end
    total++; if (bus.opcode_error !== 1'b1) begin bad++; $display("FAIL operr_flag: got %b want 1", bus.opcode_error); end
    total++; if (bus.vector_data !== 16'h1320) begin bad++; $display("FAIL operr_data: got %h want 1320", bus.vector_data); end
    bus.vector_ready = 1'b1;
    @(negedge clock);
    bus.vector_ready = 1'b0;
    total++; if (bus.opcode_error !== 1'b0) begin bad++; $display("FAIL operr_cleared: got %b want 0", bus.opcode_error); end
`ifdef PIC_INTA_STATS_EN
    total++; if (bus.error_count !== err0 + 8'd1) begin bad++; $display("FAIL operr_errcnt: got %h want %h", bus.error_count, err0 + 8'd1); end
    total++; if (bus.sequence_count !== seq0 + 16'd1) begin bad++; $display("FAIL operr_seqcnt: got %h want %h", bus.sequence_count, seq0 + 16'd1); end
`endif
  endtask

  task automatic test_hold_stall();
    int n = 0;
    pbase = pcnt;
    pic_bytes[0] = 8'h00; pic_bytes[1] = 8'h21; pic_bytes[2] = 8'h00;
    bus.u8086_or_mcs80_mode = 1'b1; bus.vector_ready = 1'b0;
    bus.interrupt_to_cpu = 1'b1;
    while (bus.vector_valid !== 1'b1 && n < 60) begin @(negedge clock); n++; end
    total++; if (bus.vector_valid !== 1'b1) begin bad++; $display("FAIL stall_timeout: got valid=%b want 1", bus.vector_valid); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      total++; if (bus.vector_valid !== 1'b1 || bus.vector_data !== 16'h0021) begin bad++; $display("FAIL stall_hold_%0d: got valid=%b data=%h want 1 0021", i, bus.vector_valid, bus.vector_data); end
      total++; if (bus.interrupt_acknowledge_n !== 1'b1) begin bad++; $display("FAIL stall_inta_%0d: got %b want 1", i, bus.interrupt_acknowledge_n); end
    end
    pbase = pcnt;
    bus.vector_ready = 1'b1;
    @(negedge clock);
    total++; if (bus.busy !== 1'b0 || bus.interrupt_acknowledge_n !== 1'b1) begin bad++; $display("FAIL stall_idle: got busy=%b inta=%b want 0 1", bus.busy, bus.interrupt_acknowledge_n); end
    @(negedge clock);
    total++; if (bus.interrupt_acknowledge_n !== 1'b0 || bus.busy !== 1'b1) begin bad++; $display("FAIL stall_restart: got inta=%b busy=%b want 0 1", bus.interrupt_acknowledge_n, bus.busy); end
    bus.interrupt_to_cpu = 1'b0;
    n = 0;
    while (bus.vector_valid !== 1'b1 && n < 60) begin @(negedge clock); n++; end
    total++; if (bus.vector_data !== 16'h0021 || bus.vector_valid !== 1'b1) begin bad++; $display("FAIL stall_second: got valid=%b data=%h want 1 0021", bus.vector_valid, bus.vector_data); end
    @(negedge clock);
    bus.vector_ready = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL stall_second_done: got busy=%b want 0", bus.busy); end
  endtask

  task automatic test_int_drop();
    int n = 0;
    pbase = pcnt;
    pic_bytes[0] = 8'h11; pic_bytes[1] = 8'h22; pic_bytes[2] = 8'h00;
    bus.u8086_or_mcs80_mode = 1'b1; bus.vector_ready = 1'b1;
    bus.interrupt_to_cpu = 1'b1;
    repeat (5) @(negedge clock);
    total++; if (bus.interrupt_acknowledge_n !== 1'b1 || bus.busy !== 1'b1) begin bad++; $display("FAIL drop_gap: got inta=%b busy=%b want 1 1", bus.interrupt_acknowledge_n, bus.busy); end
    bus.interrupt_to_cpu = 1'b0;
    while (bus.vector_valid !== 1'b1 && n < 60) begin @(negedge clock); n++; end
    total++; if (bus.vector_valid !== 1'b1) begin bad++; $display("FAIL drop_timeout: got valid=%b want 1", bus.vector_valid); end
    total++; if (bus.vector_data !== 16'h0022) begin bad++; $display("FAIL drop_data: got %h want 0022", bus.vector_data); end
    @(negedge clock);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL drop_done: got busy=%b want 0", bus.busy); end
    bus.vector_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    pbase = pcnt;
    pic_bytes[0] = 8'hCD; pic_bytes[1] = 8'h55; pic_bytes[2] = 8'h66;
    bus.u8086_or_mcs80_mode = 1'b0; bus.vector_ready = 1'b1;
    bus.interrupt_to_cpu = 1'b1;
    repeat (8) @(negedge clock);
    total++; if (bus.interrupt_acknowledge_n !== 1'b0) begin bad++; $display("FAIL rmid_pulse2: got %b want 0", bus.interrupt_acknowledge_n); end
    reset_n = 1'b0; bus.interrupt_to_cpu = 1'b0;
    @(negedge clock);
    total++; if (bus.interrupt_acknowledge_n !== 1'b1) begin bad++; $display("FAIL rmid_inta: got %b want 1", bus.interrupt_acknowledge_n); end
    total++; if (bus.vector_valid !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL rmid_state: got valid=%b busy=%b want 0 0", bus.vector_valid, bus.busy); end
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    total++; if (bus.vector_valid !== 1'b0 || bus.interrupt_acknowledge_n !== 1'b1) begin bad++; $display("FAIL rmid_after: got valid=%b inta=%b want 0 1", bus.vector_valid, bus.interrupt_acknowledge_n); end
    bus.vector_ready = 1'b0;
  endtask

  task automatic test_enable_low();
    bus.enable = 1'b0; bus.interrupt_to_cpu = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      total++; if (bus.interrupt_acknowledge_n !== 1'b1 || bus.busy !== 1'b0) begin bad++; $display("FAIL en_low_%0d: got inta=%b busy=%b want 1 0", i, bus.interrupt_acknowledge_n, bus.busy); end
    end
    bus.interrupt_to_cpu = 1'b0; bus.enable = 1'b1;
  endtask

  initial begin
    pic_bytes[0] = 8'h00; pic_bytes[1] = 8'h00; pic_bytes[2] = 8'h00;
    bus.enable = 1'b0; bus.interrupt_to_cpu = 1'b0;
    bus.u8086_or_mcs80_mode = 1'b1; bus.vector_ready = 1'b0;
    test_reset();
    test_8086();
    test_mcs80();
    test_opcode_error();
    test_hold_stall();
    test_int_drop();
    test_reset_mid();
    test_enable_low();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pic_inta_sequencer.md
# pic_inta_sequencer

CPU-side interrupt-acknowledge sequencer for the 8259A PIC. On an interrupt request from the PIC it drives the INTA pulse train: two pulses for 8086 mode, three for MCS-80 mode. It samples the bytes the PIC drives onto the data bus during each pulse. It then presents the assembled vector to the CPU core over a valid/ready handshake. It sits between the PIC's `interrupt_to_cpu` / `interrupt_acknowledge_n` / data-bus pins and the processor's interrupt entry logic.

## Interface
Parameters:
- `PULSE_CYCLES`, default 4: INTA low width in clocks. Minimum 1.
- `GAP_CYCLES`, default 2: INTA high width between pulses in clocks. Minimum 1.

Ports:
- `clock`  in  1  single system clock; all logic on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `enable`  in  1  permits starting a new sequence.
- `interrupt_to_cpu`  in  1  INT from the PIC, active high.
- `u8086_or_mcs80_mode`  in  1  1 = 8086 (two pulses), 0 = MCS-80 (three pulses).
- `data_bus`  in  8  byte driven by the PIC during INTA low.
- `interrupt_acknowledge_n`  out  1  INTA to the PIC, active low.
- `busy`  out  1  a sequence is in progress or a vector is held.
- `vector_valid`  out  1  a vector is available.
- `vector_ready`  in  1  the CPU accepts the vector.
- `vector_data`  out  16  8086 mode: {8'h00, type byte}. MCS-80 mode: {byte3, byte2}.
- `opcode_error`  out  1  MCS-80 only: byte1 != 8'hCD. Qualified by `vector_valid`.

## Operation
- States: IDLE, LOW, GAP, HOLD.
- IDLE -> LOW when `enable & interrupt_to_cpu` is sampled high. On that transition:
  - latch the mode;
  - set pulse index to 0;
  - load the timer with `PULSE_CYCLES`.
- LOW:
  - INTA is 0.
  - On the last low cycle, capture `data_bus` into byte[index].
  - If the index is the final one (1 in 8086 mode, 2 in MCS-80 mode), go to HOLD. Otherwise go to GAP and load `GAP_CYCLES`.
- GAP: INTA is 1. When the timer expires, increment the index and go to LOW.
- HOLD:
  - `vector_valid` = 1; `vector_data` and `opcode_error` are stable.
  - On `vector_valid & vector_ready`, go to IDLE.
- In 8086 mode, byte0 (the first pulse) is discarded.
- Once a sequence has started it is committed and always completes:
  - a drop of `interrupt_to_cpu` is ignored (the PIC returns its spurious IR7 vector);
  - a drop of `enable` is ignored.
- A mode-input change mid-sequence is ignored; the mode latched at start governs.
- `busy` = (state != IDLE).
- Reset values:
  - state = IDLE;
  - `interrupt_acknowledge_n` = 1;
  - `vector_valid` = 0, `busy` = 0, `opcode_error` = 0;
  - `vector_data` = 16'h0000;
  - byte registers and timer cleared.
- Reset asserted mid-pulse: INTA returns high in the same cycle reset is sampled, and no vector is produced.

## Timing
- Start latency: `interrupt_to_cpu` sampled high in IDLE at edge N -> INTA low from edge N onward, i.e. visible in cycle N+1.
- Each pulse holds INTA low for exactly `PULSE_CYCLES` clocks and high for exactly `GAP_CYCLES` clocks between pulses.
- Data sampling: at the rising edge that ends the final low cycle of each pulse.
- `vector_valid` rises in the same cycle INTA returns high after the final pulse.
- Total sequence length, to first `vector_valid` cycle:
  - 8086: 2·PULSE + GAP clocks;
  - MCS-80: 3·PULSE + 2·GAP clocks.
- HOLD lasts at least 1 cycle. With `vector_ready` held high, the transfer completes in the first HOLD cycle.
- The earliest next start is the cycle after the transfer, so INTA is high for at least 2 clocks between sequences.
- The timer is a down-counter of width $clog2(max(PULSE_CYCLES, GAP_CYCLES)+1). It wraps only by reload, never by underflow.

## Configuration
- `PIC_INTA_STATS_EN` defined:
  - adds output `sequence_count` [15:0], incremented on each vector handshake;
  - adds output `error_count` [7:0], incremented on each handshake with `opcode_error` = 1;
  - both counters saturate at all-ones and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package `pic_inta_pkg`:
  - state enum `inta_state_t` (IDLE, LOW, GAP, HOLD);
  - `CALL_OPCODE` = 8'hCD;
  - pulse-count constants `PULSES_8086` = 2 and `PULSES_MCS80` = 3.
- One sub-module, `inta_pulse_timer`: a loadable down-counter with a `load` / `value` / `expired` interface, instantiated once.

## Test plan
- 8086 mode, defaults; PIC drives 8'hFF then 8'h48 -> two 4-cycle low pulses with 2 cycles high between; `vector_valid` at cycle 10 after start; `vector_data` = 16'h0048.
- MCS-80 mode; bytes CD, 20, 13 -> three pulses; `vector_data` = 16'h1320; `opcode_error` = 0.
- MCS-80 mode; byte1 = 8'hC3 -> `opcode_error` = 1 with `vector_valid`; the stats build increments `error_count` by 1.
- `vector_ready` held low for 20 cycles -> `vector_valid` and data stable throughout; no new INTA even with `interrupt_to_cpu` high; a new sequence starts the cycle after the handshake.
- `interrupt_to_cpu` dropped after the first pulse -> the sequence completes. Separately, `reset_n` low during the second pulse -> INTA high at the reset edge and `vector_valid` = 0.
- `enable` = 0 with `interrupt_to_cpu` = 1 for 50 cycles -> INTA stays 1 and `busy` = 0.
